// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// the canonical NOP and the default reset PC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DISCARD = 2'd1,
    S_HOLD    = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential PC step; wraps modulo 2^32
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_pipelinefd.sv
// IF/ID pipeline register: clear (flush) beats enable, enable = !StallD.
module pipelineFD
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_f,
  input  logic [31:0] pc_f,
  input  logic [31:0] pcplus4_f,
  input  logic        valid_f,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (clr) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (en) begin
      instr_d   = instr_f;
      pc_d      = pc_f;
      pcplus4_d = pcplus4_f;
      valid_d   = valid_f;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0;
      pcplus4_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pc_q;
  assign PCPlus4D = pcplus4_q;
  assign ValidD   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, redirect handling across
// outstanding imem requests, a one-entry stall buffer and the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  fetch_unit_if.master       imem,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic               FetchBusyF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  redir_q, redir_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;

  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_pcplus4;
  logic         ifid_valid;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pcf_q       <= RESET_PC;
      redir_q     <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Next-state and IF/ID input selection; default IF/ID input is a bubble
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    redir_d      = redir_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    ifid_instr   = NOP_INSTR;
    ifid_pc      = pcf_q;
    ifid_pcplus4 = pc_inc(pcf_q);
    ifid_valid   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (imem.imem_ack) begin
          if (PCSrcE) begin
            pcf_d = PCTargetE;
          end else begin
            pcf_d = pc_inc(pcf_q);
            if (StallD) begin
              buf_instr_d = imem.imem_rdata;
              buf_pc_d    = pcf_q;
              state_d     = S_HOLD;
            end else begin
              ifid_instr = imem.imem_rdata;
              ifid_valid = 1'b1;
            end
          end
        end else if (PCSrcE) begin
          // The in-flight address cannot change until acked, so park the target
          redir_d = PCTargetE;
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (PCSrcE) redir_d = PCTargetE;
        if (imem.imem_ack) begin
          pcf_d   = PCSrcE ? PCTargetE : redir_q;
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_d   = PCTargetE;
          state_d = S_FETCH;
        end else if (!StallD) begin
          ifid_instr   = buf_instr_q;
          ifid_pc      = buf_pc_q;
          ifid_pcplus4 = pc_inc(buf_pc_q);
          ifid_valid   = 1'b1;
          state_d      = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs
  always_comb begin
    imem.imem_req  = reset & (state_q != S_HOLD);
    imem.imem_addr = pcf_q;
    FetchBusyF     = ((state_q == S_FETCH) & ~imem.imem_ack) | (state_q != S_FETCH);
  end

  pipelineFD u_pipelinefd (
    .clk       (clk),
    .reset     (reset),
    .en        (~StallD),
    .clr       (FlushD),
    .instr_f   (ifid_instr),
    .pc_f      (ifid_pc),
    .pcplus4_f (ifid_pcplus4),
    .valid_f   (ifid_valid),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

endmodule
